// File: rtl/segm14_scan_decoder.sv
// Loop-back monitor for a multiplexed 14-segment display bus: decodes each
// scanned digit to ASCII, assembles frames in a double buffer, flags bus errors.
module segm14_scan_decoder #(
  parameter int unsigned NUM_DIGITS = 12,
  parameter bit          HOLD_OK    = 1'b1
) (
`ifdef USE_POWER_PINS
  inout  logic                  vdd,
  inout  logic                  vss,
`endif
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_DIGITS-1:0] sel_in,
  input  logic [13:0]           segm_in,
  input  logic [3:0]            rd_addr,
  output logic [7:0]            rd_char,
  output logic                  frame_valid,
  output logic                  frame_done,
  output logic                  err_onehot,
  output logic                  err_order,
  output logic                  err_glyph,
  input  logic                  clr_err
);

  typedef enum logic {HUNT, CAPTURE} state_t;

  localparam logic [3:0] LAST = 4'(NUM_DIGITS - 1);

  state_t                state_q, state_d;
  logic [NUM_DIGITS-1:0] sel_q;
  logic [13:0]           segm_q;
  logic [3:0]            exp_q, exp_d, prev;
  logic [7:0]            wbuf [NUM_DIGITS];
  logic [7:0]            rbuf [NUM_DIGITS];

  logic [3:0] k;
  logic       any, multi;
  logic [7:0] glyph;
  logic       glyph_bad;
  logic       wr_en, commit, set_order;

  always_comb begin
    k     = '0;
    any   = 1'b0;
    multi = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (sel_q[i]) begin
        if (any) multi = 1'b1;
        any = 1'b1;
        k   = 4'(i);
      end
    end
  end

  always_comb begin
    glyph_bad = 1'b0;
    unique case (segm_q)
      14'b11101111000000: glyph = 8'h41;
      14'b10001110000000: glyph = 8'h46;
      14'b10111101000000: glyph = 8'h47;
      14'b11111100000000: glyph = 8'h4F;
      14'b10110111000000: glyph = 8'h53;
      14'b10000000010010: glyph = 8'h54;
      14'b01111100000000: glyph = 8'h55;
      14'b00001100001001: glyph = 8'h56;
      14'b01100000001000: glyph = 8'h31;
      14'b11110001000000: glyph = 8'h33;
      14'b00000000000000: glyph = 8'h20;
      default: begin
        glyph     = 8'h3F;
        glyph_bad = 1'b1;
      end
    endcase
  end

  // Right after a commit exp is 0, so the digit just written is LAST; a hold
  // on it rewrites wbuf only and never produces a second commit.
  assign prev = (exp_q == '0) ? LAST : exp_q - 4'd1;

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    wr_en     = 1'b0;
    commit    = 1'b0;
    set_order = 1'b0;
    if (any && !multi) begin
      unique case (state_q)
        HUNT: begin
          if (k == '0) begin
            wr_en   = 1'b1;
            exp_d   = 4'd1;
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (k == exp_q) begin
            wr_en = 1'b1;
            if (k == LAST) begin
              commit = 1'b1;
              exp_d  = '0;
            end else begin
              exp_d = exp_q + 4'd1;
            end
          end else if (HOLD_OK && k == prev) begin
            wr_en = 1'b1;
          end else begin
            set_order = 1'b1;
            if (k == '0) begin
              wr_en = 1'b1;
              exp_d = 4'd1;
            end else begin
              state_d = HUNT;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      segm_q      <= '0;
      state_q     <= HUNT;
      exp_q       <= '0;
      frame_valid <= 1'b0;
      frame_done  <= 1'b0;
      err_onehot  <= 1'b0;
      err_order   <= 1'b0;
      err_glyph   <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        wbuf[i] <= '0;
        rbuf[i] <= '0;
      end
    end else begin
      sel_q      <= sel_in;
      segm_q     <= segm_in;
      state_q    <= state_d;
      exp_q      <= exp_d;
      frame_done <= commit;
      if (commit) frame_valid <= 1'b1;
      // A fresh error in the clearing cycle keeps its flag set
      err_onehot <= (err_onehot & ~clr_err) | multi;
      err_order  <= (err_order  & ~clr_err) | set_order;
      err_glyph  <= (err_glyph  & ~clr_err) | (any & ~multi & glyph_bad);
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (wr_en && k == 4'(i)) wbuf[i] <= glyph;
        if (commit) rbuf[i] <= (k == 4'(i)) ? glyph : wbuf[i];
      end
    end
  end

  always_comb begin
    rd_char = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (rd_addr == 4'(i)) rd_char = rbuf[i];
    end
  end

endmodule

// File: tb/tb_segm14_scan_decoder.sv
// Scoreboard bench: stimulus queues expected frames/reads, a negedge monitor
// compares them against frame_done pulses and rd_char.
module tb_segm14_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] sel_in = '0;
  logic [13:0] segm_in = '0;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_char;
  logic        frame_valid, frame_done;
  logic        err_onehot, err_order, err_glyph;
  logic        clr_err = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  typedef struct {logic [95:0] text; int unsigned cyc;} frame_t;
  typedef struct {logic [3:0] addr; logic [7:0] ch;} rd_t;
  frame_t fq[$];
  rd_t    rq[$];

  localparam logic [95:0] FA = "GUSTAVOVF 13";
  localparam logic [95:0] FX = "VVVVVVVVVVVV";
  localparam logic [95:0] FC = "SOFT 1VAGUS3";
  localparam logic [95:0] FD = "FOG 13 TAUS1";
  localparam logic [95:0] FE = "GUST?VOVF 13";
  localparam logic [95:0] FF = "TUG 13SOFAVA";

  segm14_scan_decoder #(.NUM_DIGITS(12), .HOLD_OK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sel_in(sel_in), .segm_in(segm_in),
    .rd_addr(rd_addr), .rd_char(rd_char), .frame_valid(frame_valid),
    .frame_done(frame_done), .err_onehot(err_onehot), .err_order(err_order),
    .err_glyph(err_glyph), .clr_err(clr_err)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [13:0] seg_of(input logic [7:0] c);
    case (c)
      8'h41: return 14'b11101111000000;
      8'h46: return 14'b10001110000000;
      8'h47: return 14'b10111101000000;
      8'h4F: return 14'b11111100000000;
      8'h53: return 14'b10110111000000;
      8'h54: return 14'b10000000010010;
      8'h55: return 14'b01111100000000;
      8'h56: return 14'b00001100001001;
      8'h31: return 14'b01100000001000;
      8'h33: return 14'b11110001000000;
      8'h20: return 14'b00000000000000;
      default: return 14'h3FFF;
    endcase
  endfunction

  task automatic drive(input logic [11:0] s, input logic [13:0] g);
    @(negedge clk);
    sel_in  = s;
    segm_in = g;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive('0, '0);
  endtask

  task automatic scan(input logic [95:0] t, input int unsigned first,
                      input int unsigned last, input bit push);
    for (int unsigned i = first; i <= last; i++) begin
      drive(12'b1 << i, seg_of(t[8*(11-i) +: 8]));
      if (push && i == 11) fq.push_back('{text: t, cyc: cyc + 2});
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  task automatic chk_flags(input string name, input logic o, input logic r, input logic g);
    chk({name, "_onehot"}, err_onehot, o);
    chk({name, "_order"},  err_order,  r);
    chk({name, "_glyph"},  err_glyph,  g);
  endtask

  // Monitor: compares every frame_done against the oldest expected frame
  initial begin
    frame_t e;
    rd_t    r;
    rd_addr = '0;
    forever begin
      @(negedge clk);
      if (frame_done) begin
        if (fq.size() == 0) begin
          chk("unexpected_frame_done", 32'd1, 32'd0);
        end else begin
          e = fq.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("valid_at_done", frame_valid, 1);
          for (int i = 0; i < 12; i++) begin
            rd_addr = 4'(i);
            #1;
            chk($sformatf("frame_char%0d", i), rd_char, e.text[8*(11-i) +: 8]);
          end
        end
      end else begin
        for (int n = 0; n < 4 && rq.size() > 0; n++) begin
          r = rq.pop_front();
          rd_addr = r.addr;
          #1;
          chk($sformatf("read_addr%0d", r.addr), rd_char, r.ch);
        end
      end
    end
  end

  initial begin
    #(40 * 5000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk("rst_valid", frame_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_char", rd_char, 0);
    chk_flags("rst", 0, 0, 0);
    rst_n = 1'b1;

    // Scan starting mid-frame: ignored until digit 0
    scan(FA, 5, 11, 0);
    idle(3);
    chk("hunt_no_valid", frame_valid, 0);
    scan(FA, 0, 11, 1);
    idle(3);
    chk("a_valid", frame_valid, 1);
    chk_flags("a", 0, 0, 0);
    rq.push_back('{addr: 4'd12, ch: 8'h00});
    rq.push_back('{addr: 4'd15, ch: 8'h00});

    // Jump 3 -> 7 aborts; previous frame must survive
    scan(FX, 0, 3, 0);
    drive(12'b1 << 7, seg_of("V"));
    idle(3);
    chk("jump_order", err_order, 1);
    rq.push_back('{addr: 4'd0, ch: "G"});
    rq.push_back('{addr: 4'd2, ch: "S"});
    rq.push_back('{addr: 4'd11, ch: "3"});
    scan(FX, 4, 11, 0);
    idle(2);
    scan(FC, 0, 11, 1);
    idle(3);
    pulse_clr();
    chk_flags("clr1", 0, 0, 0);

    // Two-hot select and idle gaps inside a frame
    scan(FD, 0, 5, 0);
    drive(12'h003, seg_of("A"));
    scan(FD, 6, 6, 0);
    idle(1);
    scan(FD, 7, 11, 1);
    idle(3);
    chk_flags("onehot", 1, 0, 0);
    pulse_clr();
    chk_flags("clr2", 0, 0, 0);

    // Unknown pattern on digit 4 decodes to '?'
    scan(FE, 0, 11, 1);
    idle(3);
    chk_flags("glyph", 0, 0, 1);
    rq.push_back('{addr: 4'd4, ch: 8'h3F});
    idle(2);
    pulse_clr();
    chk("clr3_glyph", err_glyph, 0);

    // New error coincides with clr_err: error wins
    drive(12'b1, 14'h3FFF);
    @(negedge clk); sel_in = '0; segm_in = '0; clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    chk("clr_vs_new_glyph", err_glyph, 1);
    chk("clr_vs_new_order", err_order, 0);

    // Asynchronous reset mid-frame
    scan(FF, 1, 3, 0);
    @(negedge clk);
    #3 rst_n = 1'b0;
    sel_in = '0;
    #1;
    chk("arst_valid", frame_valid, 0);
    chk("arst_done", frame_done, 0);
    chk("arst_char", rd_char, 0);
    chk_flags("arst", 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    idle(1);

    // Held select on digit 3 overwrites it
    scan(FF, 0, 2, 0);
    drive(12'b1 << 3, seg_of("O"));
    scan(FF, 3, 11, 1);
    idle(3);
    chk("f_valid", frame_valid, 1);
    chk_flags("f", 0, 0, 0);

    for (int i = 0; i < 20 && (fq.size() > 0 || rq.size() > 0); i++) @(negedge clk);
    chk("queues_drained", fq.size() + rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/segm14_scan_decoder.md
Name: segm14_scan_decoder

Overview:
- Receives the multiplexed 12-digit, 14-segment display bus (one-hot digit select plus segment pattern, one digit per clock) and rebuilds the displayed text.
- Decodes each segment pattern to an 8-bit ASCII code and assembles complete frames in a double buffer. Exposes the frame through a random-read port with status and sticky error flags.
- Sits beside the display scanner as the loop-back monitor and self-test checker for the display path.

Parameters:
NUM_DIGITS, 12, digits per frame (legal 2..16); sel_in width equals NUM_DIGITS
HOLD_OK, 1, 1 = the same select presented on consecutive cycles is a legal hold; 0 = it is an order error

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
sel_in  input  NUM_DIGITS  digit select from the scanner, one-hot, bit0 = first digit
segm_in  input  14  segment pattern for the selected digit
rd_addr  input  4  read index into the completed frame
rd_char  output  8  ASCII code at rd_addr (combinational from the read buffer)
frame_valid  output  1  at least one complete frame has been captured
frame_done  output  1  one-cycle pulse when a new frame is committed
err_onehot  output  1  sticky: sel_in had more than one bit set
err_order  output  1  sticky: digit index out of sequence
err_glyph  output  1  sticky: segm_in pattern not in the glyph table
clr_err  input  1  synchronous clear of all three sticky errors
(vdd/vss inout power pins under USE_POWER_PINS)

Behaviour:
- Reset (async, rst_n=0): state=HUNT; input registers, both buffers, rd_char source, frame_valid, frame_done and all error flags = 0.
- Stage 1: sel_in/segm_in are registered at every edge.
- Stage 2: the registered sample is classified and decoded at the following edge.
- Total latency is 2 edges from input to buffer write or frame_done.
- Classification of the registered sel:
  - all-zero: idle. Ignored; no write, no error.
  - more than one bit set: err_onehot<=1. Sample discarded; state unchanged.
  - exactly one bit set: index k = bit position.
- Glyph table (segm[13:0] -> ASCII):
  - 11101111000000->'A'
  - 10001110000000->'F'
  - 10111101000000->'G'
  - 11111100000000->'O'
  - 10110111000000->'S'
  - 10000000010010->'T'
  - 01111100000000->'U'
  - 00001100001001->'V'
  - 01100000001000->'1'
  - 11110001000000->'3'
  - 00000000000000->' '
  - Any other pattern -> 8'h3F '?' and err_glyph<=1.
- FSM:
  - HUNT: ignore every index except 0. On k=0: write wbuf[0], set exp=1, go to CAPTURE.
  - CAPTURE:
    - k==exp: write wbuf[k], exp<=exp+1.
    - k==exp-1 (hold): if HOLD_OK, overwrite wbuf[k]; otherwise treat as an order error.
    - Any other k: err_order<=1. If k==0, restart the capture (write wbuf[0], exp=1, stay in CAPTURE); otherwise go to HUNT.
  - Commit: when k==NUM_DIGITS-1 is written, at the same edge:
    - rbuf <= wbuf, with the last digit merged in;
    - frame_done<=1 for exactly one cycle;
    - frame_valid<=1 (stays set until reset);
    - exp wraps to 0 and the FSM stays in CAPTURE.
- A partial frame never reaches rbuf. rbuf holds the last complete frame until the next commit.
- rd_char = rbuf[rd_addr]; rd_addr >= NUM_DIGITS returns 8'h00.
- Sticky errors:
  - They hold until clr_err or reset.
  - If clr_err and a new error occur in the same cycle, the new error wins (flag stays 1).
- Reset mid-frame discards wbuf contents and returns to HUNT.
- Idle (all-zero) cycles inside a frame do not break the sequence.

Test Plan:
- Reset, then scan digits 0..11 with G,U,S,T,A,V,O,V,F,space,1,3, one per clock -> frame_done pulses once, 2 cycles after digit 11. Reads 0..11 return 47,55,53,54,41,56,4F,56,46,20,31,33; frame_valid=1; no errors.
- Start the scan at digit 5 -> no writes until digit 0 appears. First frame_done comes after the following 0..11 run; err_order stays 0.
- Mid-frame jump from index 3 to index 7 -> err_order=1 and the FSM returns to HUNT. rbuf keeps the previous frame; frame_done is withheld until a full 0..11 run completes.
- sel_in=12'h003 for one cycle -> err_onehot=1; sample ignored; the frame continues. Assert clr_err -> all flags read 0 the next cycle.
- Digit 4 pattern 14'h3FFF -> rd_char at index 4 = 3F after commit; err_glyph=1.
- Assert rst_n=0 asynchronously mid-frame -> all outputs 0 immediately. rd_addr=12 -> rd_char=00.
